// File: rtl/exec_mem_display.sv
// ALU + 64x32 data memory (access and display read ports) + 8-digit seven-segment scanner. ALU_MULDIV_EN adds MUL/DIV.
// Latency: ALU, memory reads, an/seg are combinational; memory writes land on the rising edge.
// Backpressure: none; every input is consumed each cycle.
module exec_mem_display #(
    parameter int SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_x,
    input  logic [31:0] alu_y,
    input  logic [3:0]  alu_op,
    output logic [31:0] alu_r,
    output logic [31:0] alu_r2,
    output logic        alu_of,
    output logic        alu_cf,
    output logic        alu_eq,
    input  logic [5:0]  ram_addr,
    input  logic [5:0]  ram_addr_display,
    input  logic [31:0] ram_din,
    input  logic        ram_we,
    input  logic [1:0]  ram_mode,
    input  logic [1:0]  ram_byte,
    output logic [31:0] ram_dout,
    output logic [31:0] ram_display,
    input  logic [2:0]  display,
    input  logic [31:0] total_cycles,
    input  logic [31:0] condi_num,
    input  logic [31:0] uncondi_num,
    input  logic [31:0] condi_suc_num,
    input  logic [31:0] syscall_out,
    input  logic [31:0] show_pc,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    logic [32:0] w_sum;
    logic [32:0] w_diff;

    assign w_sum  = {1'b0, alu_x} + {1'b0, alu_y};
    assign w_diff = {1'b0, alu_x} - {1'b0, alu_y};

`ifdef ALU_MULDIV_EN
    logic [63:0] w_prod;
    assign w_prod = $signed(alu_x) * $signed(alu_y);
`endif

    always_comb begin
        alu_r  = 32'd0;
        alu_r2 = 32'd0;
        alu_of = 1'b0;
        alu_cf = 1'b0;
        alu_eq = (alu_x == alu_y);
        case (alu_op)
            4'd0: alu_r = alu_x << alu_y[4:0];
            4'd1: alu_r = $signed(alu_x) >>> alu_y[4:0];
            4'd2: alu_r = alu_x >> alu_y[4:0];
`ifdef ALU_MULDIV_EN
            4'd3: begin
                alu_r  = w_prod[31:0];
                alu_r2 = w_prod[63:32];
            end
            4'd4: begin
                // Divide-by-zero yields quotient 0 and passes the dividend through as remainder
                if (alu_y == 32'd0) begin
                    alu_r  = 32'd0;
                    alu_r2 = alu_x;
                end else begin
                    alu_r  = alu_x / alu_y;
                    alu_r2 = alu_x % alu_y;
                end
            end
`endif
            4'd5: begin
                alu_r  = w_sum[31:0];
                alu_cf = w_sum[32];
                alu_of = (alu_x[31] == alu_y[31]) && (w_sum[31] != alu_x[31]);
            end
            4'd6: begin
                alu_r  = w_diff[31:0];
                alu_cf = w_diff[32];
                alu_of = (alu_x[31] != alu_y[31]) && (w_diff[31] != alu_x[31]);
            end
            4'd7:  alu_r = alu_x & alu_y;
            4'd8:  alu_r = alu_x | alu_y;
            4'd9:  alu_r = alu_x ^ alu_y;
            4'd10: alu_r = ~(alu_x | alu_y);
            4'd11: alu_r = {31'd0, $signed(alu_x) < $signed(alu_y)};
            4'd12: alu_r = {31'd0, alu_x < alu_y};
            default: alu_r = 32'd0;
        endcase
    end

    logic [31:0] r_mem [64];
    logic [31:0] w_wdata;

    assign ram_dout    = r_mem[ram_addr];
    assign ram_display = r_mem[ram_addr_display];

    // Sub-word writes merge into the current word so untouched lanes survive
    always_comb begin
        w_wdata = ram_dout;
        case (ram_mode)
            2'b00: begin
                case (ram_byte)
                    2'd0: w_wdata[7:0]   = ram_din[7:0];
                    2'd1: w_wdata[15:8]  = ram_din[7:0];
                    2'd2: w_wdata[23:16] = ram_din[7:0];
                    default: w_wdata[31:24] = ram_din[7:0];
                endcase
            end
            2'b01: begin
                if (ram_byte[1]) w_wdata[31:16] = ram_din[15:0];
                else             w_wdata[15:0]  = ram_din[15:0];
            end
            default: w_wdata = ram_din;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) r_mem[i] <= 32'd0;
        end else if (ram_we) begin
            r_mem[ram_addr] <= w_wdata;
        end
    end

    logic [SCAN_BITS+2:0] r_scan;

    always_ff @(posedge clk) begin
        if (rst) r_scan <= '0;
        else     r_scan <= r_scan + 1'b1;
    end

    logic [2:0]  w_digit;
    logic [31:0] w_val;
    logic [3:0]  w_nib;

    assign w_digit = r_scan[SCAN_BITS+2:SCAN_BITS];
    assign an      = ~(8'b1 << w_digit);
    assign w_nib   = w_val[{w_digit, 2'b00} +: 4];

    always_comb begin
        w_val = 32'd0;
        case (display)
            3'd0: w_val = ram_display;
            3'd1: w_val = total_cycles;
            3'd2: w_val = condi_num;
            3'd3: w_val = uncondi_num;
            3'd4: w_val = condi_suc_num;
            3'd5: w_val = syscall_out;
            3'd6: w_val = show_pc;
            default: w_val = 32'd0;
        endcase
    end

    always_comb begin
        seg = 8'hC0;
        case (w_nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
    end

endmodule

// File: tb/tb_exec_mem_display.sv
// Directed bench for exec_mem_display with a 1-bit scan prescaler (16-clock full refresh).
module tb_exec_mem_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_x, alu_y;
    logic [3:0]  alu_op;
    logic [31:0] alu_r, alu_r2;
    logic        alu_of, alu_cf, alu_eq;
    logic [5:0]  ram_addr, ram_addr_display;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [1:0]  ram_mode, ram_byte;
    logic [31:0] ram_dout, ram_display;
    logic [2:0]  display;
    logic [31:0] total_cycles, condi_num, uncondi_num, condi_suc_num, syscall_out, show_pc;
    logic [7:0]  an, seg;

    int vectors = 0;
    int errors  = 0;

    exec_mem_display #(.SCAN_BITS(1)) dut (
        .clk(clk), .rst(rst),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_r(alu_r), .alu_r2(alu_r2), .alu_of(alu_of), .alu_cf(alu_cf), .alu_eq(alu_eq),
        .ram_addr(ram_addr), .ram_addr_display(ram_addr_display), .ram_din(ram_din),
        .ram_we(ram_we), .ram_mode(ram_mode), .ram_byte(ram_byte),
        .ram_dout(ram_dout), .ram_display(ram_display),
        .display(display), .total_cycles(total_cycles), .condi_num(condi_num),
        .uncondi_num(uncondi_num), .condi_suc_num(condi_suc_num),
        .syscall_out(syscall_out), .show_pc(show_pc),
        .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        alu_op = op;
        alu_x  = x;
        alu_y  = y;
        #1;
    endtask

    logic [7:0] exp_abc [8];

    initial begin
        exp_abc = '{8'hC6, 8'h83, 8'h88, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        rst = 1'b1; alu_x = 0; alu_y = 0; alu_op = 0;
        ram_addr = 0; ram_addr_display = 0; ram_din = 0; ram_we = 0; ram_mode = 0; ram_byte = 0;
        display = 0; total_cycles = 32'h11111111; condi_num = 32'h22222222; uncondi_num = 0;
        condi_suc_num = 0; syscall_out = 0; show_pc = 32'h00000ABC;

        // Reset state
        tick();
        check("rst_an", {24'd0, an}, 32'hFE);
        check("rst_seg", {24'd0, seg}, 32'hC0);
        check("rst_dout", ram_dout, 32'd0);
        check("rst_disp", ram_display, 32'd0);
        display = 3'd1; #1;
        check("rst_seg_total", {24'd0, seg}, 32'hF9);
        display = 3'd0;
        rst = 1'b0;

        // ALU
        alu(4'd5, 32'h7FFFFFFF, 32'd1);
        check("add_r", alu_r, 32'h80000000);
        check("add_of", {31'd0, alu_of}, 32'd1);
        check("add_cf", {31'd0, alu_cf}, 32'd0);
        check("add_eq", {31'd0, alu_eq}, 32'd0);
        alu(4'd5, 32'hFFFFFFFF, 32'd1);
        check("add_carry_r", alu_r, 32'd0);
        check("add_carry_cf", {31'd0, alu_cf}, 32'd1);
        check("add_carry_of", {31'd0, alu_of}, 32'd0);
        alu(4'd6, 32'd0, 32'd1);
        check("sub_r", alu_r, 32'hFFFFFFFF);
        check("sub_cf", {31'd0, alu_cf}, 32'd1);
        check("sub_of", {31'd0, alu_of}, 32'd0);
        alu(4'd6, 32'h80000000, 32'd1);
        check("sub_ovf", {31'd0, alu_of}, 32'd1);
        alu(4'd1, 32'h80000000, 32'd4);
        check("sra", alu_r, 32'hF8000000);
        alu(4'd2, 32'h80000000, 32'd4);
        check("srl", alu_r, 32'h08000000);
        alu(4'd0, 32'h00000003, 32'h00000024);
        check("sll_y_low5", alu_r, 32'h00000030);
        alu(4'd11, 32'hFFFFFFFF, 32'd1);
        check("slt", alu_r, 32'd1);
        alu(4'd12, 32'hFFFFFFFF, 32'd1);
        check("sltu", alu_r, 32'd0);
        alu(4'd10, 32'h0F0F0000, 32'h000000F0);
        check("nor", alu_r, 32'hF0F0FF0F);
        alu(4'd9, 32'h5A5A5A5A, 32'h5A5A5A5A);
        check("xor_r", alu_r, 32'd0);
        check("xor_eq", {31'd0, alu_eq}, 32'd1);
        check("xor_of", {31'd0, alu_of}, 32'd0);
        alu(4'd14, 32'h12345678, 32'h1);
        check("op14", alu_r, 32'd0);
`ifdef ALU_MULDIV_EN
        alu(4'd3, 32'hFFFFFFFF, 32'd2);
        check("mul_lo", alu_r, 32'hFFFFFFFE);
        check("mul_hi", alu_r2, 32'hFFFFFFFF);
        alu(4'd4, 32'd7, 32'd2);
        check("div_q", alu_r, 32'd3);
        check("div_rem", alu_r2, 32'd1);
        alu(4'd4, 32'd5, 32'd0);
        check("div0_q", alu_r, 32'd0);
        check("div0_rem", alu_r2, 32'd5);
`else
        alu(4'd3, 32'hFFFFFFFF, 32'd2);
        check("mul_off_r", alu_r, 32'd0);
        check("mul_off_r2", alu_r2, 32'd0);
        alu(4'd4, 32'd7, 32'd2);
        check("div_off_r", alu_r, 32'd0);
        check("div_off_r2", alu_r2, 32'd0);
`endif

        // Memory: word write, byte merge, halfword merge
        ram_addr = 6'd3; ram_addr_display = 6'd3;
        ram_din = 32'h12345678; ram_mode = 2'b10; ram_we = 1'b1; #1;
        check("wr_same_cycle", ram_dout, 32'd0);
        tick();
        check("wr_word", ram_dout, 32'h12345678);
        ram_din = 32'hFFFFFFAB; ram_mode = 2'b00; ram_byte = 2'd1; #1;
        check("byte_same_cycle", ram_dout, 32'h12345678);
        tick();
        ram_we = 1'b0;
        check("byte_dout", ram_dout, 32'h1234AB78);
        check("byte_disp", ram_display, 32'h1234AB78);
        ram_din = 32'h9999CDEF; ram_mode = 2'b01; ram_byte = 2'd2; ram_we = 1'b1;
        tick();
        ram_we = 1'b0;
        check("half_hi", ram_dout, 32'hCDEFAB78);
        ram_addr = 6'd4; #1;
        check("neighbour", ram_dout, 32'd0);

        // Fill all words, then reset with a concurrent write
        ram_mode = 2'b10; ram_we = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ram_addr = 6'(i);
            ram_din  = 32'hA5000000 | 32'(i + 1);
            tick();
        end
        ram_we = 1'b0; ram_addr_display = 6'd63; #1;
        check("fill_63", ram_display, 32'hA5000040);
        ram_addr = 6'd5; ram_din = 32'hDEADBEEF; ram_we = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; ram_we = 1'b0;
        check("rst_an_again", {24'd0, an}, 32'hFE);
        for (int i = 0; i < 64; i++) begin
            ram_addr = 6'(i);
            #1;
            check($sformatf("rst_word_%0d", i), ram_dout, 32'd0);
        end

        // Display scan over show_pc, then constant-zero source
        display = 3'd6; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                check($sformatf("scan_an_%0d", k / 2), {24'd0, an}, 32'(~(8'h01 << (k / 2))) & 32'hFF);
                check($sformatf("scan_seg_%0d", k / 2), {24'd0, seg}, {24'd0, exp_abc[k / 2]});
            end
            tick();
        end
        check("scan_wrap_an", {24'd0, an}, 32'hFE);
        check("scan_wrap_seg", {24'd0, seg}, 32'hC6);
        display = 3'd7;
        for (int k = 0; k < 16; k++) begin
            #1;
            check($sformatf("zero_seg_%0d", k), {24'd0, seg}, 32'hC0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
